fcmp_arbiter: RTL
=================

// Module: fcmp_arbiter
// PURPOSE
//  Shares one single-precision compare datapath (feq/flt/fle) between two requesters.
//  Round-robin (or fixed-priority) arbitration, 2-stage pipeline (operand reg -> result reg),
//  one shared response channel tagged with requester id. Sits between issue logic and the FPU.
//  Throughput 1 op/cycle; in-order completion.
// PARAMETERS
//  RR_EN  1  1: round-robin between requesters; 0: fixed priority, requester 0 always wins
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  req_valid  in   2   bit i: requester i presents an op
//  req_op     in   4   [2i+1:2i] op of requester i: 00 feq, 01 flt, 10 fle, 11 reserved
//  req_x1     in   64  [32i+31:32i] operand x1 of requester i (IEEE-754 single)
//  req_x2     in   64  [32i+31:32i] operand x2 of requester i
//  req_ready  out  2   bit i: op of requester i accepted this cycle (one-hot or zero)
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer accepts response
//  rsp_id     out  1   requester index owning the response
//  rsp_data   out  32  {31'b0, result bit}
//  busy       out  1   s1_v | s2_v
// BEHAVIOUR
//  - Reset (async, immediate): s1_v=0, s2_v=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0,
//    rr_last=1 (req 0 wins first). In-flight ops dropped, no response issued for them.
//  - Stages: s1 {v,id,op,x1,x2}, s2 {v,id,res}. s2_adv = ~s2_v | rsp_ready;
//    s1_adv = ~s1_v | s2_adv. Accept allowed only when s1_adv.
//  - Grant (comb.): if s1_adv: one valid -> grant it; both valid -> RR_EN=1: grant ~rr_last,
//    RR_EN=0: grant 0. req_ready = grant. req_ready may depend on req_valid; requesters must
//    not make req_valid depend on req_ready. rr_last <= granted id on every grant.
//  - Transfer on edge: grant -> s1 loaded; s1_v & s2_adv -> s2 loaded with compare of s1;
//    s1_v cleared if s2_adv and no new grant. rsp_valid=s2_v; s2 cleared on rsp_ready & ~new.
//  - Latency: accepted at edge k -> rsp_valid high after edge k+1 (if no backpressure).
//  - Backpressure: rsp_* held stable while rsp_valid & ~rsp_ready; max 2 ops in flight;
//    req_ready=00 when both stages full and rsp_ready=0. Accept + retire same cycle legal.
//  - Compare (sign-magnitude on raw bits, NaN not special-cased, +0 == -0):
//    bz = x1[30:0]==0 & x2[30:0]==0; lt_m = x1[30:0]<x2[30:0]; gt_m = x1[30:0]>x2[30:0]
//    flt: s1=0,s2=0 -> lt_m; 0,1 -> 0; 1,0 -> ~bz; 1,1 -> gt_m
//    feq: (x1==x2) | bz;  fle: flt | feq;  op 11 -> result 0, response still issued.
//  - Responses returned in acceptance order; rsp_id equals id at acceptance.
// TESTING
//  1 Reset: assert rst with 2 ops in flight, rsp_ready=0 -> same cycle rsp_valid=0, busy=0,
//    no response after release; first subsequent contention grants req 0.
//  2 flt req0 x1=BF800000 x2=3F800000, rsp_ready=1 -> req_ready=01, 2 edges later
//    rsp_valid=1, rsp_id=0, rsp_data=1; swapped operands -> rsp_data=0.
//  3 Zeros x1=80000000 x2=00000000: feq->1, flt->0, fle->1; flt x1=C0000000
//    x2=BF800000 -> 1 (-2 < -1); op=11 any operands -> rsp_data=0.
//  4 Both req_valid=11 held 6 cycles, rsp_ready=1: RR_EN=1 -> rsp_id 0,1,0,1,0,1;
//    RR_EN=0 -> all 0, req1 never granted.
//  5 3 ops back-to-back, rsp_ready=0 for 4 cycles: req_ready=00 after 2 accepted, rsp
//    held stable; release -> 3 responses in order, no loss or duplication.
//  6 Random ops/operands/valid/ready 10k cycles vs reference model: data, id and order match.

Source files
------------

// File: rtl/fcmp_arbiter.sv
// fcmp_arbiter: two requesters share one 2-stage single-precision compare pipe (feq/flt/fle).
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module fcmp_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_x1,
  input  logic [63:0] req_x2,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  logic        s1_v;
  logic        s1_id;
  logic [1:0]  s1_op;
  logic [31:0] s1_x1;
  logic [31:0] s1_x2;

  logic        s2_v;
  logic        s2_id;
  logic        s2_res;

  logic        rr_last;

  logic        s2_adv;
  logic        s1_adv;
  logic [1:0]  grant;
  logic        grant_any;
  logic        grant_id;
  logic [1:0]  sel_op;
  logic [31:0] sel_x1;
  logic [31:0] sel_x2;

  logic        bz;
  logic        lt_m;
  logic        gt_m;
  logic        eq_raw;
  logic        feq_r;
  logic        flt_r;
  logic        cmp_res;

  assign s2_adv = ~s2_v | rsp_ready;
  assign s1_adv = ~s1_v | s2_adv;

  // Grant only when stage 1 can take a new op this edge.
  always_comb begin
    grant = 2'b00;
    if (s1_adv) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
          if (RR_EN) grant = rr_last ? 2'b01 : 2'b10;
          else       grant = 2'b01;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  assign grant_any = |grant;
  assign grant_id  = grant[1];
  assign req_ready = grant;

  assign sel_op = grant_id ? req_op[3:2]   : req_op[1:0];
  assign sel_x1 = grant_id ? req_x1[63:32] : req_x1[31:0];
  assign sel_x2 = grant_id ? req_x2[63:32] : req_x2[31:0];

  // Sign-magnitude compare on raw bits; both zero magnitudes compare equal.
  assign bz     = (s1_x1[30:0] == 31'd0) & (s1_x2[30:0] == 31'd0);
  assign lt_m   = s1_x1[30:0] < s1_x2[30:0];
  assign gt_m   = s1_x1[30:0] > s1_x2[30:0];
  assign eq_raw = s1_x1 == s1_x2;
  assign feq_r  = eq_raw | bz;

  always_comb begin
    flt_r = 1'b0;
    case ({s1_x1[31], s1_x2[31]})
      2'b00:   flt_r = lt_m;
      2'b01:   flt_r = 1'b0;
      2'b10:   flt_r = ~bz;
      2'b11:   flt_r = gt_m;
      default: flt_r = 1'b0;
    endcase
  end

  always_comb begin
    cmp_res = 1'b0;
    case (s1_op)
      OP_FEQ:  cmp_res = feq_r;
      OP_FLT:  cmp_res = flt_r;
      OP_FLE:  cmp_res = flt_r | feq_r;
      default: cmp_res = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_id   <= 1'b0;
      s1_op   <= 2'b00;
      s1_x1   <= 32'd0;
      s1_x2   <= 32'd0;
      s2_v    <= 1'b0;
      s2_id   <= 1'b0;
      s2_res  <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_id  <= s1_id;
          s2_res <= cmp_res;
        end
      end
      if (s1_adv) begin
        s1_v <= grant_any;
        if (grant_any) begin
          s1_id <= grant_id;
          s1_op <= sel_op;
          s1_x1 <= sel_x1;
          s1_x2 <= sel_x2;
        end
      end
      if (grant_any) rr_last <= grant_id;
    end
  end

  assign rsp_valid = s2_v;
  assign rsp_id    = s2_id;
  assign rsp_data  = {31'd0, s2_res};
  assign busy      = s1_v | s2_v;

endmodule

`default_nettype wire
